// File: rtl/morty_bus_arbiter.sv
// morty_bus_arbiter: shares one Wishbone classic port between LSU I and D.
// Optional stalled-strobe timeout: define MORTY_ARB_TIMEOUT_EN.
module morty_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iaddr_i,
  input  logic        icyc_i,
  input  logic        istb_i,
  output logic [31:0] idat_o,
  output logic        iack_o,
  output logic        ierr_o,
  input  logic [31:0] daddr_i,
  input  logic [31:0] ddat_i,
  input  logic [3:0]  dsel_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  output logic [31:0] ddat_o,
  output logic        dack_o,
  output logic        derr_o,
  output logic [31:0] maddr_o,
  output logic [31:0] mdat_o,
  output logic [3:0]  msel_o,
  output logic        mwe_o,
  output logic        mcyc_o,
  output logic        mstb_o,
  input  logic [31:0] mdat_i,
  input  logic        mack_i,
  input  logic        merr_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       cyc_raw, stb_raw;
  logic       own_i, own_d;
  logic       starved;
  logic       to_hit;

  assign own_i   = (state_q == GNT_I);
  assign own_d   = (state_q == GNT_D);
  assign starved = (starve_q >= 4'(STARVE_LIMIT));

  // Arbitration in IDLE, release when the owner drops cyc
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (dcyc_i && !(icyc_i && starved)) begin
          state_d = GNT_D;
          if (icyc_i && starve_q != 4'hf)
            starve_d = starve_q + 4'd1;
        end else if (icyc_i) begin
          state_d  = GNT_I;
          starve_d = '0;
        end
      end
      GNT_I: if (!icyc_i) state_d = IDLE;
      GNT_D: if (!dcyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and starvation counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Shared-bus request mux selected by the current owner
  always_comb begin
    maddr_o = '0;
    mdat_o  = '0;
    msel_o  = '0;
    mwe_o   = 1'b0;
    cyc_raw = 1'b0;
    stb_raw = 1'b0;
    unique case (state_q)
      GNT_I: begin
        maddr_o = iaddr_i;
        msel_o  = 4'hf;
        cyc_raw = icyc_i;
        stb_raw = istb_i;
      end
      GNT_D: begin
        maddr_o = daddr_i;
        mdat_o  = ddat_i;
        msel_o  = dsel_i;
        mwe_o   = dwe_i;
        cyc_raw = dcyc_i;
        stb_raw = dstb_i;
      end
      default: ;
    endcase
  end

`ifdef MORTY_ARB_TIMEOUT_EN
  logic [7:0] to_q, to_d;
  logic       stall;

  assign stall  = stb_raw && !mack_i && !merr_i;
  assign to_hit = stall && (to_q == 8'(TIMEOUT - 1));

  // Stalled-strobe counter, cleared on any response or owner change
  always_comb begin
    to_d = to_q;
    if (state_d != state_q || mack_i || merr_i || to_hit)
      to_d = '0;
    else if (stall)
      to_d = to_q + 8'd1;
  end

  // Timeout counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |8'(TIMEOUT);
  assign to_hit = 1'b0;
`endif

  assign mcyc_o = cyc_raw & ~to_hit;
  assign mstb_o = stb_raw & ~to_hit;

  assign idat_o = mdat_i;
  assign ddat_o = mdat_i;
  assign iack_o = own_i & mack_i;
  assign dack_o = own_d & mack_i;
  assign ierr_o = own_i & (merr_i | to_hit);
  assign derr_o = own_d & (merr_i | to_hit);

  assign gnt_o = state_q;

endmodule

// File: tb/tb_morty_bus_arbiter.sv
// tb_morty_bus_arbiter: directed vectors for the I/D Wishbone arbiter.
// Timeout sequence runs only when MORTY_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_morty_bus_arbiter;

`ifdef MORTY_ARB_TIMEOUT_EN
  localparam int unsigned TB_TO = 8;
`else
  localparam int unsigned TB_TO = 255;
`endif

  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] DA = 32'h0000_0200;
  localparam logic [31:0] DD = 32'hCAFE_0001;
  localparam logic [3:0]  DS = 4'h4;
  localparam logic        DW = 1'b1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] iaddr_i;
  logic        icyc_i, istb_i;
  logic [31:0] idat_o;
  logic        iack_o, ierr_o;
  logic [31:0] daddr_i, ddat_i;
  logic [3:0]  dsel_i;
  logic        dwe_i, dcyc_i, dstb_i;
  logic [31:0] ddat_o;
  logic        dack_o, derr_o;
  logic [31:0] maddr_o, mdat_o;
  logic [3:0]  msel_o;
  logic        mwe_o, mcyc_o, mstb_o;
  logic [31:0] mdat_i;
  logic        mack_i, merr_i;
  logic [1:0]  gnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  morty_bus_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT(TB_TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .iaddr_i(iaddr_i), .icyc_i(icyc_i), .istb_i(istb_i),
    .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
    .daddr_i(daddr_i), .ddat_i(ddat_i), .dsel_i(dsel_i),
    .dwe_i(dwe_i), .dcyc_i(dcyc_i), .dstb_i(dstb_i),
    .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
    .maddr_o(maddr_o), .mdat_o(mdat_o), .msel_o(msel_o),
    .mwe_o(mwe_o), .mcyc_o(mcyc_o), .mstb_o(mstb_o),
    .mdat_i(mdat_i), .mack_i(mack_i), .merr_i(merr_i),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, ic, is, dc, ds, ak, er;
    logic [1:0] g;
    logic       cy, sb;
    logic [3:0] rt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic r, ic, is, dc, ds, ak, er,
    input logic [1:0] g,
    input logic cy, sb,
    input logic [3:0] rt
  );
    vec_t v;
    v.r = r; v.ic = ic; v.is = is;
    v.dc = dc; v.ds = ds; v.ak = ak; v.er = er;
    v.g = g; v.cy = cy; v.sb = sb; v.rt = rt;
    vq.push_back(v);
  endfunction

  function automatic logic [70:0] mexp(
    input logic [1:0] g, input logic cy, sb
  );
    case (g)
      2'b01:   return {IA, 32'h0, 4'hf, 1'b0, cy, sb};
      2'b10:   return {DA, DD, DS, DW, cy, sb};
      default: return 71'h0;
    endcase
  endfunction

  task automatic chk(
    input string nm, input int idx,
    input logic [70:0] got, input logic [70:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h want %h", nm, idx, got, exp);
    end
  endtask

  task automatic drv(
    input logic r, ic, is, dc, ds, ak, er,
    input logic [31:0] md
  );
    rst_i = r; icyc_i = ic; istb_i = is;
    dcyc_i = dc; dstb_i = ds;
    mack_i = ak; merr_i = er; mdat_i = md;
    iaddr_i = IA; daddr_i = DA; ddat_i = DD;
    dsel_i = DS; dwe_i = DW;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] md;

    // I only, ack two cycles after strobe
    add(0,0,0,0,0,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,0,0,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,0,0,0,0, 2'b01,1,1,4'h0);
    add(0,1,1,0,0,0,0, 2'b01,1,1,4'h0);
    add(0,1,1,0,0,1,0, 2'b01,1,1,4'h8);
    add(0,0,0,0,0,0,0, 2'b01,0,0,4'h0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,4'h0);
    // simultaneous request: D first, dead cycle, then I
    add(0,1,1,1,1,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,1,1,1,0, 2'b10,1,1,4'h2);
    add(0,1,1,0,0,0,0, 2'b10,0,0,4'h0);
    add(0,1,1,0,0,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,0,0,1,0, 2'b01,1,1,4'h8);
    add(0,0,0,0,0,0,0, 2'b01,0,0,4'h0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,4'h0);
    // starvation: four D grants, fifth goes to I
    for (int k = 0; k < 4; k++) begin
      add(0,1,1,1,1,0,0, 2'b00,0,0,4'h0);
      add(0,1,1,1,1,1,0, 2'b10,1,1,4'h2);
      add(0,1,1,0,0,0,0, 2'b10,0,0,4'h0);
    end
    add(0,1,1,1,1,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,1,1,1,0, 2'b01,1,1,4'h8);
    add(0,0,0,1,1,0,0, 2'b01,0,0,4'h0);
    add(0,0,0,1,1,0,0, 2'b00,0,0,4'h0);
    add(0,0,0,1,1,1,0, 2'b10,1,1,4'h2);
    add(0,0,0,0,0,0,0, 2'b10,0,0,4'h0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,4'h0);
    // error routing, then reset mid-transfer
    add(0,1,1,1,1,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,1,1,0,1, 2'b10,1,1,4'h1);
    add(0,1,1,1,1,1,0, 2'b10,1,1,4'h2);
    add(1,1,1,1,1,0,0, 2'b10,1,1,4'h0);
    add(1,1,1,1,1,1,0, 2'b00,0,0,4'h0);
    add(0,1,1,1,1,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,1,1,1,0, 2'b10,1,1,4'h2);
    add(0,1,1,0,0,0,0, 2'b10,0,0,4'h0);
    add(0,1,1,0,0,0,0, 2'b00,0,0,4'h0);
    add(0,1,1,0,0,1,0, 2'b01,1,1,4'h8);
    add(0,0,0,0,0,0,0, 2'b01,0,0,4'h0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,4'h0);

    drv(1,0,0,0,0,0,0, 32'h0);
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      md = (i < 8) ? 32'h13 : (32'hD000_0000 | 32'(i));
      drv(vq[i].r, vq[i].ic, vq[i].is, vq[i].dc, vq[i].ds,
          vq[i].ak, vq[i].er, md);
      #1;
      chk("gnt", i, 71'(gnt_o), 71'(vq[i].g));
      chk("mbus", i,
          {maddr_o, mdat_o, msel_o, mwe_o, mcyc_o, mstb_o},
          mexp(vq[i].g, vq[i].cy, vq[i].sb));
      chk("ackerr", i, 71'({iack_o, ierr_o, dack_o, derr_o}),
          71'(vq[i].rt));
      chk("rdata", i, 71'({idat_o, ddat_o}), 71'({md, md}));
    end

    // reset must clear a saturated starvation count
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drv(0,1,1,1,1,0,0, 32'h55);
      @(negedge clk);
      drv(0,1,1,1,1,1,0, 32'h55);
      #1;
      chk("starve_d_gnt", k, 71'(gnt_o), 71'(2'b10));
      @(negedge clk);
      drv(0,1,1,0,0,0,0, 32'h55);
    end
    @(negedge clk);
    drv(1,1,1,1,1,0,0, 32'h55);
    @(negedge clk);
    drv(0,1,1,1,1,0,0, 32'h55);
    #1;
    chk("rst_idle", 0, 71'(gnt_o), 71'(2'b00));
    @(negedge clk);
    drv(0,1,1,1,1,0,0, 32'h55);
    #1;
    chk("rst_starve_clr", 0, 71'(gnt_o), 71'(2'b10));
    @(negedge clk);
    drv(0,0,0,0,0,0,0, 32'h55);
    @(negedge clk);
    drv(0,0,0,0,0,0,0, 32'h55);
    @(negedge clk);
    drv(0,0,0,0,0,0,0, 32'h55);
    #1;
    chk("pre_to_idle", 0, 71'(gnt_o), 71'(2'b00));

`ifdef MORTY_ARB_TIMEOUT_EN
    // I strobes into a slave that never responds
    @(negedge clk);
    drv(0,1,1,0,0,0,0, 32'h66);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      drv(0,1,1,0,0,0,0, 32'h66);
      #1;
      chk("to_gnt", n, 71'(gnt_o), 71'(2'b01));
      chk("to_ierr", n, 71'({ierr_o, iack_o, derr_o}),
          71'({(n == 8), 1'b0, 1'b0}));
      chk("to_stb", n, 71'({mcyc_o, mstb_o}),
          (n == 8) ? 71'(2'b00) : 71'(2'b11));
    end
    @(negedge clk);
    drv(0,0,0,0,0,0,0, 32'h66);
    #1;
    chk("to_drop", 0, 71'({gnt_o, ierr_o}), 71'({2'b01, 1'b0}));
    @(negedge clk);
    drv(0,0,0,0,0,0,0, 32'h66);
    #1;
    chk("to_idle", 0, 71'(gnt_o), 71'(2'b00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
